// File: rtl/hpdcache_core_arbiter.sv
// N-to-1 core requester arbiter (fixed-priority or round-robin) with late abort/tag/PMA forwarding and sid-based response demux.
// Zero-latency request/response paths, late signals one cycle after acceptance; a stalled grant is held until out_req_ready_i.
package hpdcache_core_arbiter_pkg;
    typedef struct packed {
        logic [2:0]  sid;
        logic [15:0] data;
    } core_req_t;

    typedef struct packed {
        logic [2:0]  sid;
        logic [15:0] data;
    } core_rsp_t;

    typedef logic [23:0] core_tag_t;

    typedef struct packed {
        logic uncacheable;
        logic io;
    } core_pma_t;
endpackage

module hpdcache_core_arbiter
    import hpdcache_core_arbiter_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter bit          RR_EN = 1'b1,
    parameter int unsigned SID_W = 3,
    parameter type hpdcache_req_t = core_req_t,
    parameter type hpdcache_rsp_t = core_rsp_t,
    parameter type hpdcache_tag_t = core_tag_t,
    parameter type hpdcache_pma_t = core_pma_t
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,

    input  logic [NREQ-1:0]          in_req_valid_i,
    output logic [NREQ-1:0]          in_req_ready_o,
    input  hpdcache_req_t            in_req_i       [NREQ],
    input  logic [NREQ-1:0]          in_req_abort_i,
    input  hpdcache_tag_t            in_req_tag_i   [NREQ],
    input  hpdcache_pma_t            in_req_pma_i   [NREQ],

    output logic [NREQ-1:0]          in_rsp_valid_o,
    output hpdcache_rsp_t            in_rsp_o       [NREQ],

    output logic                     out_req_valid_o,
    input  logic                     out_req_ready_i,
    output hpdcache_req_t            out_req_o,
    output logic                     out_req_abort_o,
    output hpdcache_tag_t            out_req_tag_o,
    output hpdcache_pma_t            out_req_pma_o,

    input  logic                     out_rsp_valid_i,
    input  hpdcache_rsp_t            out_rsp_i,
    output logic                     rsp_sid_err_o
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  r_rr_ptr;
    logic             r_lock;
    logic [IDX_W-1:0] r_lock_idx;
    logic [IDX_W-1:0] r_late_idx;
    logic             r_late_vld;

    logic [IDX_W-1:0] w_rr_grant;
    logic [IDX_W-1:0] w_fp_grant;
    logic [IDX_W-1:0] w_grant;
    logic [NREQ-1:0]  w_gnt_oh;
    logic [NREQ-1:0]  w_rr_next;
    logic             w_accept;

    // Scan two laps so the search can wrap past NREQ-1 after meeting the pointer.
    always_comb begin
        logic seen;
        logic found;
        seen       = 1'b0;
        found      = 1'b0;
        w_rr_grant = '0;
        for (int k = 0; k < 2 * NREQ; k++) begin
            if (k < NREQ && r_rr_ptr[k % NREQ]) seen = 1'b1;
            if (seen && !found && in_req_valid_i[k % NREQ]) begin
                w_rr_grant = IDX_W'(k % NREQ);
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        w_fp_grant = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (in_req_valid_i[i]) w_fp_grant = IDX_W'(i);
        end
    end

    assign w_grant = r_lock ? r_lock_idx : (RR_EN ? w_rr_grant : w_fp_grant);

    always_comb begin
        w_gnt_oh  = '0;
        w_rr_next = '0;
        for (int i = 0; i < NREQ; i++) w_gnt_oh[i] = (w_grant == IDX_W'(i));
        for (int i = 0; i < NREQ; i++) w_rr_next[(i + 1) % NREQ] = w_gnt_oh[i];
    end

    assign out_req_valid_o = |in_req_valid_i;
    assign out_req_o       = in_req_i[w_grant];
    assign in_req_ready_o  = w_gnt_oh & {NREQ{out_req_ready_i}};
    assign w_accept        = out_req_valid_o && out_req_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr   <= NREQ'(1);
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_late_idx <= '0;
            r_late_vld <= 1'b0;
        end else begin
            r_late_vld <= w_accept;
            if (w_accept) begin
                r_lock     <= 1'b0;
                r_late_idx <= w_grant;
                r_rr_ptr   <= w_rr_next;
            end else if (out_req_valid_o) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_grant;
            end
        end
    end

    // Late signals belong to whoever was accepted last cycle, not to the current grant.
    assign out_req_abort_o = r_late_vld && in_req_abort_i[r_late_idx];
    assign out_req_tag_o   = in_req_tag_i[r_late_idx];
    assign out_req_pma_o   = in_req_pma_i[r_late_idx];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            in_rsp_valid_o[i] = out_rsp_valid_i && (out_rsp_i.sid == SID_W'(i));
            in_rsp_o[i]       = out_rsp_i;
        end
    end

    assign rsp_sid_err_o = out_rsp_valid_i && ({1'b0, out_rsp_i.sid} >= (SID_W + 1)'(NREQ));

    for (genvar i = 0; i < NREQ; i++) begin : g_sid_chk
        a_sid_match: assert property (@(posedge clk_i) disable iff (!rst_ni)
            in_req_valid_i[i] |-> (in_req_i[i].sid == SID_W'(i)));
    end

endmodule
